// File: rtl/uart_apb_pkg.sv
// Shared types and defaults for the two-requester APB arbiter that fronts a uart_top.
package uart_apb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     wdata;
    logic [DEF_DATA_W/8-1:0]   strb;
  } apb_req_t;

endpackage

// File: rtl/uart_apb_arbiter_if.sv
// Requester-side transaction port and APB bus port of the arbiter.
interface uart_apb_req_if
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                  valid;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   strb;
  logic                  done;
  logic [DATA_W-1:0]     rdata;
  logic                  err;

  modport master (output valid, write, addr, wdata, strb, input done, rdata, err);
  modport slave  (input valid, write, addr, wdata, strb, output done, rdata, err);
endinterface

interface uart_apb_arbiter_if
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/uart_apb_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
      else                gnt_o = req_i;
    end
  end

endmodule

// File: rtl/uart_apb_arbiter.sv
// Shares one APB slave port between two requesters: round-robin grant,
// SETUP/ACCESS sequencing with wait-states, and a pready watchdog.
module uart_apb_arbiter
  import uart_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter logic [15:0] TIMEOUT = 16'd256
) (
  input  logic                pclk,
  input  logic                preset_n,
  uart_apb_req_if.slave       req0,
  uart_apb_req_if.slave       req1,
  uart_apb_arbiter_if.master  apb
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [15:0]         wd_q, wd_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]          gnt;
  logic                finish;
  logic [DATA_W-1:0]   cap_rdata;
  logic                cap_err;
  logic                sel_write;

  rr_arb2 u_arb (
    .req_i  ({req1.valid, req0.valid}),
    .last_i (last_q),
    .en_i   (state_q == ST_IDLE),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    wd_d      = wd_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    finish    = 1'b0;
    cap_rdata = '0;
    cap_err   = 1'b0;
    sel_write = gnt[1] ? req1.write : req0.write;

    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          win_d    = gnt[1];
          last_d   = gnt[1];
          pwrite_d = sel_write;
          paddr_d  = gnt[1] ? req1.addr  : req0.addr;
          pwdata_d = gnt[1] ? req1.wdata : req0.wdata;
          pstrb_d  = sel_write ? (gnt[1] ? req1.strb : req0.strb) : '0;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        wd_d      = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready is checked first so a response on the expiry cycle still completes normally
        if (apb.pready) begin
          finish    = 1'b1;
          cap_rdata = pwrite_q ? '0 : apb.prdata;
          cap_err   = apb.pslverr;
        end else if ((TIMEOUT != 16'd0) && (wd_q == TIMEOUT - 16'd1)) begin
          finish    = 1'b1;
          cap_rdata = '0;
          cap_err   = 1'b1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      state_d   = ST_DONE;
      if (win_q) begin
        done1_d  = 1'b1;
        rdata1_d = cap_rdata;
        err1_d   = cap_err;
      end else begin
        done0_d  = 1'b1;
        rdata0_d = cap_rdata;
        err0_d   = cap_err;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      wd_q      <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      wd_q      <= wd_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

  assign req0.done  = done0_q;
  assign req0.rdata = rdata0_q;
  assign req0.err   = err0_q;
  assign req1.done  = done1_q;
  assign req1.rdata = rdata1_q;
  assign req1.err   = err1_q;

endmodule
